pwm_sched_ctrl: RTL
===================

Name: pwm_sched_ctrl

Overview:
- Run-time controller for the PWM output stage.
- Accepts period/duty configuration over a valid/ready handshake and holds it in shadow registers.
- Applies new configuration only at period boundaries, so output pulses are never truncated.
- Sequences start/stop with a drain phase so a disable always completes the current period. Sits between the configuration source and the output flip-flop driving the pin.

Parameters:
- CNT_W, 8, width of the period counter, period and duty fields.
- RST_PERIOD, 2**CNT_W-1, period value loaded into shadow and active registers at reset.
- RST_DUTY, 0, duty value loaded into shadow and active registers at reset.

Ports:
- ck  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  level enable; sampled on posedge ck.
- cfg_valid  in  1  configuration offer.
- cfg_period  in  CNT_W  period register value; the period is cfg_period+1 cycles.
- cfg_duty  in  CNT_W  number of high cycles per period.
- cfg_ready  out  1  high when no update is pending; transfer occurs when cfg_valid&&cfg_ready.
- pwm_out  out  1  registered PWM output.
- period_start  out  1  registered one-cycle pulse on the first cycle of each period.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Interface: one clock (ck); synchronous, active-high reset (rst).
- Reset values:
  - state=IDLE, cnt=0, pend=0.
  - Shadow and active registers = RST_PERIOD/RST_DUTY.
  - pwm_out=0, period_start=0, busy=0, cfg_ready=1.
  - rst asserted mid-period aborts immediately at the next edge. No drain; any pending update is discarded.
- Config handshake:
  - On a transfer, the shadow registers are loaded and pend is set to 1.
  - cfg_ready = !pend, driven combinationally from the pend register. A second config therefore cannot overwrite a pending one.
  - Accepted in any state.
- States:
  - IDLE: cnt held at 0; pwm_out=0.
    - en=1 -> RUN. In the same edge, if pend=1, copy shadow to active and clear pend.
  - RUN: cnt increments each cycle.
    - At cnt==per_a, cnt wraps to 0. If pend=1, copy shadow to active and clear pend.
    - en=0 sampled -> DRAIN; counting continues uninterrupted.
  - DRAIN: counts like RUN.
    - en=1 -> RUN with no disturbance to cnt or output.
    - At wrap with en=0 -> IDLE. The pend transfer still occurs at this wrap.
- Registered outputs are aligned with the next-state cnt:
  - pwm_out = (cnt_next < duty_a_next) when state_next is RUN or DRAIN, else 0.
  - period_start = 1 when state_next is RUN or DRAIN and cnt_next==0.
  - Latency: en rising sampled at edge N gives period_start=1 and the first pwm_out value after edge N (1 cycle).
- Arithmetic:
  - Period length = per_a+1 cycles. High cycles = min(duty_a, per_a+1).
  - duty_a=0 -> constantly low.
  - duty_a>per_a -> constantly high, with period_start still pulsing.
  - per_a=0 -> 1-cycle period; period_start is high continuously while running.
  - cnt is unsigned CNT_W bits. The compare is unsigned; no overflow, because wrap is forced at per_a.
- Simultaneous events:
  - Config accepted in the same cycle as a wrap goes to shadow only and applies at the following wrap, because the wrap uses the pre-edge pend.
  - Config accepted in IDLE on the same edge as en rising is not used for that first period.
  - When the IDLE->RUN edge loads the active registers, the first period uses the newly loaded values.

Decomposition:
- Package pwm_pkg:
  - state enum {IDLE, RUN, DRAIN}.
  - CNT_W default constant.
  - Reset constants.
- Sub-module pwm_shadow_reg: shadow/active register pair plus pend flag.
  - Inputs: load (the handshake), commit (wrap or IDLE->RUN).
  - Outputs: active values, cfg_ready.
  - Controller FSM, counter and output compare stay in pwm_sched_ctrl.

Test Plan:
- Reset, then cfg period=4 duty=2, then en=1: cfg_ready drops for 1 cycle, then rises at the IDLE->RUN edge. Output is high,high,low,low,low repeating (5-cycle period), with period_start every 5th cycle, first one 1 cycle after en is sampled.
- Mid-period update: while running 4/2, send period=9 duty=7 at cnt=1. The current period stays 5 cycles/2 high. The next period is 10 cycles/7 high. cfg_ready stays low from acceptance until the wrap.
- Disable drain: deassert en at cnt=2 of period=4. Output completes cnt 3,4, then busy=0 and pwm_out=0. Re-asserting en at cnt=3 of a second run keeps RUN with no glitch.
- Boundaries: with duty=0, pwm_out is always 0. With period=3 duty=6, pwm_out is always 1. With period=0 duty=1, period_start stays at 1 and pwm_out stays at 1.
- Same-edge events: cfg_valid held through a wrap with pend=0 is accepted at the wrap edge and applied one period later. cfg_valid with pend=1 sees cfg_ready=0 and no transfer occurs.
- rst asserted at cnt=3 while RUN with pend=1: the next cycle shows all outputs at reset values and cfg_ready=1. A following en=1 runs at RST_PERIOD/RST_DUTY, giving a 256-cycle period and constant low.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM scheduling controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pwm_pkg;

    localparam int CNT_W_DEF    = 8;
    localparam int RST_DUTY_DEF = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // All-ones period for a counter of the given width.
    function automatic int rst_period(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/pwm_shadow_reg.sv
// Shadow/active configuration register pair with a single pending-update flag.
// Latency: a load lands in shadow on the accepting edge; commit copies it to active on the commit edge.
// Backpressure: ready_o = !pend, so a pending update can never be overwritten.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   load_i, per_i, duty_i  accepted configuration (handshake already qualified with ready_o)
//   commit_i               period boundary or IDLE->RUN edge
//   per_a_o                active period (registered)
//   duty_nxt_o             duty value that will be active after this edge
//   ready_o                high when no update is pending
module pwm_shadow_reg #(
    parameter int CNT_W      = 8,
    parameter int RST_PERIOD = 255,
    parameter int RST_DUTY   = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] per_i,
    input  logic [CNT_W-1:0] duty_i,
    input  logic             commit_i,
    output logic [CNT_W-1:0] per_a_o,
    output logic [CNT_W-1:0] duty_nxt_o,
    output logic             ready_o
);

    logic [CNT_W-1:0] per_s_q,  per_s_d;
    logic [CNT_W-1:0] duty_s_q, duty_s_d;
    logic [CNT_W-1:0] per_a_q,  per_a_d;
    logic [CNT_W-1:0] duty_a_q, duty_a_d;
    logic             pend_q,   pend_d;

    // load needs pend=0 and the copy needs pend=1, so they never collide:
    // a load on a commit edge stays in shadow until the following commit.
    always_comb begin
        per_s_d  = per_s_q;
        duty_s_d = duty_s_q;
        per_a_d  = per_a_q;
        duty_a_d = duty_a_q;
        pend_d   = pend_q;
        if (commit_i && pend_q) begin
            per_a_d  = per_s_q;
            duty_a_d = duty_s_q;
            pend_d   = 1'b0;
        end
        if (load_i) begin
            per_s_d  = per_i;
            duty_s_d = duty_i;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            per_s_q  <= CNT_W'(RST_PERIOD);
            duty_s_q <= CNT_W'(RST_DUTY);
            per_a_q  <= CNT_W'(RST_PERIOD);
            duty_a_q <= CNT_W'(RST_DUTY);
            pend_q   <= 1'b0;
        end else begin
            per_s_q  <= per_s_d;
            duty_s_q <= duty_s_d;
            per_a_q  <= per_a_d;
            duty_a_q <= duty_a_d;
            pend_q   <= pend_d;
        end
    end

    assign per_a_o    = per_a_q;
    assign duty_nxt_o = duty_a_d;
    assign ready_o    = !pend_q;

endmodule

// File: rtl/pwm_sched_ctrl.sv
// PWM run-time controller: boundary-aligned config updates and drained start/stop sequencing.
// Latency: en sampled high at edge N gives period_start and the first pwm_out value after edge N.
// Backpressure: cfg_ready low while an accepted update waits for the next period boundary.
//
// Ports:
//   ck, rst                          clock, synchronous active-high reset
//   en                               level enable
//   cfg_valid/cfg_ready              configuration handshake
//   cfg_period, cfg_duty             period (length = cfg_period+1) and high-cycle count
//   pwm_out, period_start            registered outputs aligned with the next counter value
//   busy                             controller not IDLE
module pwm_sched_ctrl
    import pwm_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int RST_PERIOD = rst_period(CNT_W),
    parameter int RST_DUTY   = RST_DUTY_DEF
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    output logic             cfg_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             pwm_q,   pwm_d;
    logic             ps_q,    ps_d;

    logic [CNT_W-1:0] per_a;
    logic [CNT_W-1:0] duty_nxt;
    logic             wrap;
    logic             commit;
    logic             load;

    assign load   = cfg_valid && cfg_ready;
    // Counter never exceeds per_a because active values only change at a wrap.
    assign wrap   = (state_q != IDLE) && (cnt_q == per_a);
    assign commit = ((state_q == IDLE) && en) || wrap;

    pwm_shadow_reg #(
        .CNT_W      (CNT_W),
        .RST_PERIOD (RST_PERIOD),
        .RST_DUTY   (RST_DUTY)
    ) u_shadow (
        .clk_i      (ck),
        .rst_i      (rst),
        .load_i     (load),
        .per_i      (cfg_period),
        .duty_i     (cfg_duty),
        .commit_i   (commit),
        .per_a_o    (per_a),
        .duty_nxt_o (duty_nxt),
        .ready_o    (cfg_ready)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) state_d = RUN;
            end
            RUN: begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
                if (!en) state_d = DRAIN;
            end
            DRAIN: begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
                if (en)        state_d = RUN;
                else if (wrap) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from next-state values so they line up with cnt_q.
    always_comb begin
        pwm_d = (state_d != IDLE) && (cnt_d < duty_nxt);
        ps_d  = (state_d != IDLE) && (cnt_d == '0);
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            ps_q    <= ps_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign busy         = (state_q != IDLE);

endmodule
